// File: rtl/cp0_reg_file_pkg.sv
// Shared CP0 types: register snapshot, write masks, register numbers, ExcCodes
// and Status/Cause bit positions.
package cp0_reg_file_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  localparam creg_addr_t CREG_BADVADDR  = 5'd8;
  localparam creg_addr_t CREG_COUNT     = 5'd9;
  localparam creg_addr_t CREG_COMPARE   = 5'd11;
  localparam creg_addr_t CREG_STATUS    = 5'd12;
  localparam creg_addr_t CREG_CAUSE     = 5'd13;
  localparam creg_addr_t CREG_EPC       = 5'd14;
  localparam creg_addr_t CREG_ERROR_EPC = 5'd30;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int IM_LO  = 8;
  localparam int IM_HI  = 15;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;
  localparam int IP_LO  = 8;
  localparam int IP_HI  = 15;
  localparam int EXC_LO = 2;
  localparam int EXC_HI = 6;

  typedef struct packed {
    word_t badvaddr;
    word_t count;
    word_t compare;
    word_t status;
    word_t cause;
    word_t epc;
    word_t error_epc;
  } cp0_t;

  // Software-writable bits per register; Status exposes BEV, IM, EXL and IE.
  localparam cp0_t CP0_MASK = '{
    badvaddr:  32'h0000_0000,
    count:     32'hFFFF_FFFF,
    compare:   32'hFFFF_FFFF,
    status:    32'h0040_FF03,
    cause:     32'h0000_0300,
    epc:       32'hFFFF_FFFF,
    error_epc: 32'hFFFF_FFFF
  };

  function automatic word_t mask_merge(word_t old_val, word_t new_val, word_t mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_reg_file_timer.sv
// Count/Compare timer with clock divider; the timer-interrupt flag exists only
// when CP0_TIMER_INT_EN is defined, otherwise TI is tied to 0.
module cp0_timer
  import cp0_reg_file_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  count_we,
  input  logic  compare_we,
  input  word_t wdata,
  output word_t count,
  output word_t compare,
  output logic  ti_next
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  word_t         count_q, count_d;
  word_t         compare_q, compare_d;
  logic          tick;

  assign tick = (div_q == DW'(COUNT_DIV - 1));

  // NOTE: always_comb assigns every output a default first, so no latch can be inferred.
  always_comb begin
    div_d     = tick ? '0 : div_q + DW'(1);
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    if (count_we) begin
      div_d   = '0;
      count_d = wdata;
    end
    if (compare_we) compare_d = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic ti_q, ti_d;

  // TI is sticky from the Count update that hits Compare until Compare is rewritten.
  always_comb begin
    ti_d = ti_q | ((tick | count_we) && (count_d == compare_q));
    if (compare_we) ti_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ti_q <= 1'b0;
    else       ti_q <= ti_d;
  end

  assign ti_next = ti_d;
`else
  assign ti_next = 1'b0;
`endif

  assign count   = count_q;
  assign compare = compare_q;

endmodule

// File: rtl/cp0_reg_file.sv
// CP0 register bank: MTC0 commit, exception/ERET recording, Cause.IP sampling
// and interrupt request. Timer interrupt gated by CP0_TIMER_INT_EN.
module cp0_reg_file
  import cp0_reg_file_pkg::*;
#(
  parameter int unsigned COUNT_DIV    = 2,
  parameter word_t       RESET_STATUS = 32'h0040_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wen,
  input  creg_addr_t waddr,
  input  word_t      wdata,
  input  logic       exc_valid,
  input  logic [4:0] exc_code,
  input  word_t      exc_pc,
  input  logic       exc_in_ds,
  input  word_t      exc_badvaddr,
  input  logic       eret,
  input  logic [5:0] ext_int,
  output cp0_t       cp0,
  output word_t      epc,
  output logic       int_pending
);

  word_t status_q, status_d;
  word_t cause_q, cause_d;
  word_t epc_q, epc_d;
  word_t badvaddr_q, badvaddr_d;
  word_t error_epc_q, error_epc_d;
  logic  int_pending_q, int_pending_d;

  word_t count, compare;
  logic  ti_next;
  logic  mtc0;

  // An exception in the same cycle swallows the MTC0.
  assign mtc0 = wen & ~exc_valid;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0 && (waddr == CREG_COUNT)),
    .compare_we (mtc0 && (waddr == CREG_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti_next    (ti_next)
  );

  always_comb begin
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    badvaddr_d  = badvaddr_q;
    error_epc_d = error_epc_q;

    if (exc_valid) begin
      cause_d[EXC_HI:EXC_LO] = exc_code;
      if (!status_q[ST_EXL]) begin
        epc_d          = exc_in_ds ? exc_pc - 32'd4 : exc_pc;
        cause_d[CA_BD] = exc_in_ds;
      end
      status_d[ST_EXL] = 1'b1;
      if (exc_code == EXC_ADEL || exc_code == EXC_ADES) badvaddr_d = exc_badvaddr;
    end else begin
      if (wen) begin
        case (waddr)
          CREG_BADVADDR:  badvaddr_d  = mask_merge(badvaddr_q, wdata, CP0_MASK.badvaddr);
          CREG_STATUS:    status_d    = mask_merge(status_q, wdata, CP0_MASK.status);
          CREG_CAUSE:     cause_d     = mask_merge(cause_q, wdata, CP0_MASK.cause);
          CREG_EPC:       epc_d       = mask_merge(epc_q, wdata, CP0_MASK.epc);
          CREG_ERROR_EPC: error_epc_d = mask_merge(error_epc_q, wdata, CP0_MASK.error_epc);
          default: ;
        endcase
      end
      // ERET wins over a same-cycle MTC0 Status that tries to set EXL.
      if (eret) status_d[ST_EXL] = 1'b0;
    end

    cause_d[IP_LO+6:IP_LO+2] = ext_int[4:0];
    cause_d[IP_HI]           = ext_int[5] | ti_next;
    cause_d[CA_TI]           = ti_next;

    int_pending_d = status_d[ST_IE] & ~status_d[ST_EXL]
                  & (|(cause_d[IP_HI:IP_LO] & status_d[IM_HI:IM_LO]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q      <= RESET_STATUS;
      cause_q       <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      error_epc_q   <= '0;
      int_pending_q <= 1'b0;
    end else begin
      status_q      <= status_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      error_epc_q   <= error_epc_d;
      int_pending_q <= int_pending_d;
    end
  end

  assign cp0 = '{
    badvaddr:  badvaddr_q,
    count:     count,
    compare:   compare,
    status:    status_q,
    cause:     cause_q,
    epc:       epc_q,
    error_epc: error_epc_q
  };
  assign epc         = epc_q;
  assign int_pending = int_pending_q;

endmodule
